// File: rtl/t02_rf_pkg.sv
// Shared constants and types for the scoreboarded integer register file.
package t02_rf_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned IDX_W_DEF    = $clog2(NUM_REGS_DEF);

  typedef logic [IDX_W_DEF-1:0]  reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/t02_rf_scoreboard.sv
// Pending-write bit per register with flush > set > clear priority and a registered any_busy.
module t02_rf_scoreboard
  import t02_rf_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                sb_set,
  input  logic [IDX_W-1:0]    sb_set_index,
  input  logic                sb_clear,
  input  logic [IDX_W-1:0]    sb_clear_index,
  input  logic                sb_flush,
  output logic [NUM_REGS-1:0] pending,
  output logic                any_busy
);

  logic [NUM_REGS-1:0] pending_d, pending_q;
  logic                any_busy_d, any_busy_q;
  logic                set_ok;

  // Clear is applied before set so a new producer on the same index wins.
  always_comb begin
    pending_d = pending_q;
    set_ok    = sb_set && !((ZERO_REG != 0) && (sb_set_index == '0));
    if (sb_flush) begin
      pending_d = '0;
    end else begin
      if (sb_clear) pending_d[sb_clear_index] = 1'b0;
      if (set_ok)   pending_d[sb_set_index]   = 1'b1;
    end
    any_busy_d = |pending_d;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      pending_q  <= '0;
      any_busy_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      any_busy_q <= any_busy_d;
    end
  end

  assign pending  = pending_q;
  assign any_busy = any_busy_q;

endmodule

// File: rtl/t02_register_file_sb.sv
// Parametrised integer register file with optional write bypass and a RAW-hazard scoreboard.
module t02_register_file_sb
  import t02_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     reg_write,
  input  logic [IDX_W-1:0]         write_index,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*IDX_W-1:0]  read_index,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     sb_set,
  input  logic [IDX_W-1:0]         sb_set_index,
  input  logic                     sb_clear,
  input  logic [IDX_W-1:0]         sb_clear_index,
  input  logic                     sb_flush,
  output logic                     any_busy
);

  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [IDX_W-1:0]    rd_idx;
  logic                wr_ok;

  t02_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk            (clk),
    .nRST           (nRST),
    .sb_set         (sb_set),
    .sb_set_index   (sb_set_index),
    .sb_clear       (sb_clear),
    .sb_clear_index (sb_clear_index),
    .sb_flush       (sb_flush),
    .pending        (pending),
    .any_busy       (any_busy)
  );

  // Writes to the hardwired zero register are dropped.
  always_comb begin
    regs_d = regs_q;
    wr_ok  = reg_write && !((ZERO_REG != 0) && (write_index == '0));
    if (wr_ok) regs_d[write_index] = write_data;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Per-port read mux, bypass and busy masking; zero register beats bypass.
  always_comb begin
    read_data = '0;
    read_busy = '0;
    rd_idx    = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      rd_idx = read_index[k*IDX_W +: IDX_W];
      if ((ZERO_REG != 0) && (rd_idx == '0)) begin
        read_data[k*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && reg_write && (write_index == rd_idx)) begin
        read_data[k*DATA_W +: DATA_W] = write_data;
      end else begin
        read_data[k*DATA_W +: DATA_W] = regs_q[rd_idx];
      end
      read_busy[k] = pending[rd_idx] &&
                     !((BYPASS != 0) && sb_clear && (sb_clear_index == rd_idx));
    end
  end

endmodule

// File: tb/tb_t02_register_file_sb.sv
// Table-driven and randomized checks of the register file against a behavioural model.
module tb_t02_register_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration stimulus shared by the bypass and no-bypass instances.
  logic        nrst, reg_write, sb_set, sb_clear, sb_flush;
  logic [4:0]  write_index, sb_set_index, sb_clear_index;
  logic [31:0] write_data;
  logic [9:0]  read_index;
  logic [63:0] rd_a, rd_b;
  logic [1:0]  busy_a, busy_b;
  logic        any_a, any_b;

  // Narrow three-port instance.
  logic        p_we, p_set, p_clr, p_flush;
  logic [2:0]  p_wi, p_si, p_ci;
  logic [15:0] p_wd;
  logic [8:0]  p_ri;
  logic [47:0] p_rd;
  logic [2:0]  p_busy;
  logic        p_any;

  t02_register_file_sb dut_a (
    .clk(clk), .nRST(nrst), .reg_write(reg_write), .write_index(write_index),
    .write_data(write_data), .read_index(read_index), .read_data(rd_a),
    .read_busy(busy_a), .sb_set(sb_set), .sb_set_index(sb_set_index),
    .sb_clear(sb_clear), .sb_clear_index(sb_clear_index), .sb_flush(sb_flush),
    .any_busy(any_a));

  t02_register_file_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .nRST(nrst), .reg_write(reg_write), .write_index(write_index),
    .write_data(write_data), .read_index(read_index), .read_data(rd_b),
    .read_busy(busy_b), .sb_set(sb_set), .sb_set_index(sb_set_index),
    .sb_clear(sb_clear), .sb_clear_index(sb_clear_index), .sb_flush(sb_flush),
    .any_busy(any_b));

  t02_register_file_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3)) dut_p (
    .clk(clk), .nRST(nrst), .reg_write(p_we), .write_index(p_wi),
    .write_data(p_wd), .read_index(p_ri), .read_data(p_rd),
    .read_busy(p_busy), .sb_set(p_set), .sb_set_index(p_si),
    .sb_clear(p_clr), .sb_clear_index(p_ci), .sb_flush(p_flush),
    .any_busy(p_any));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Architectural model: register contents and set of pending destinations.
  logic [31:0] mem [32];
  logic [31:0] pend;

  function automatic logic [31:0] m_read(input bit byp, input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (byp && reg_write && write_index == idx) return write_data;
    return mem[idx];
  endfunction

  function automatic logic m_busy(input bit byp, input logic [4:0] idx);
    return pend[idx] && !(byp && sb_clear && sb_clear_index == idx);
  endfunction

  task automatic model_edge();
    if (!nrst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      pend = 32'd0;
    end else begin
      if (reg_write && write_index != 5'd0) mem[write_index] = write_data;
      if (sb_flush) pend = 32'd0;
      else begin
        if (sb_clear) pend[sb_clear_index] = 1'b0;
        if (sb_set && sb_set_index != 5'd0) pend[sb_set_index] = 1'b1;
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [4:0] idx;
    if (!nrst) return;
    for (int k = 0; k < 2; k++) begin
      idx = read_index[k*5 +: 5];
      chk($sformatf("%s rd_byp[%0d]", tag, k), 64'(rd_a[k*32 +: 32]), 64'(m_read(1'b1, idx)));
      chk($sformatf("%s rd_nobyp[%0d]", tag, k), 64'(rd_b[k*32 +: 32]), 64'(m_read(1'b0, idx)));
      chk($sformatf("%s busy_byp[%0d]", tag, k), 64'(busy_a[k]), 64'(m_busy(1'b1, idx)));
      chk($sformatf("%s busy_nobyp[%0d]", tag, k), 64'(busy_b[k]), 64'(m_busy(1'b0, idx)));
    end
    chk({tag, " any_byp"}, 64'(any_a), 64'(pend != 32'd0));
    chk({tag, " any_nobyp"}, 64'(any_b), 64'(pend != 32'd0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    nrst = 1'b1; reg_write = 1'b0; write_index = '0; write_data = '0;
    read_index = '0; sb_set = 1'b0; sb_set_index = '0; sb_clear = 1'b0;
    sb_clear_index = '0; sb_flush = 1'b0;
    p_we = 1'b0; p_wi = '0; p_wd = '0; p_ri = '0; p_set = 1'b0; p_si = '0;
    p_clr = 1'b0; p_ci = '0; p_flush = 1'b0;
  endtask

  typedef struct {
    bit chk_en; bit rst_n; bit we; logic [4:0] wi; logic [31:0] wd;
    logic [4:0] ri0, ri1; bit set; logic [4:0] si; bit clr; logic [4:0] ci; bit flush;
    logic [31:0] e_rd0, e_rd1, n_rd0, n_rd1; logic [1:0] e_busy, n_busy; bit e_any;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(bit c, bit r, bit we, logic [4:0] wi, logic [31:0] wd,
                             logic [4:0] r0, logic [4:0] r1, bit st, logic [4:0] si,
                             bit cl, logic [4:0] ci, bit fl, logic [31:0] e0, logic [31:0] e1,
                             logic [31:0] n0, logic [31:0] n1, logic [1:0] eb, logic [1:0] nb,
                             bit ea);
    vec_t t;
    t.chk_en = c; t.rst_n = r; t.we = we; t.wi = wi; t.wd = wd; t.ri0 = r0; t.ri1 = r1;
    t.set = st; t.si = si; t.clr = cl; t.ci = ci; t.flush = fl;
    t.e_rd0 = e0; t.e_rd1 = e1; t.n_rd0 = n0; t.n_rd1 = n1;
    t.e_busy = eb; t.n_busy = nb; t.e_any = ea;
    return t;
  endfunction

  function automatic logic [4:0] rnd_idx();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    idle();
    nrst = 1'b0;
    tick();
    tick();
    idle();

    // Narrow instance: reset state, write x7, three-port read, busy and bypass.
    p_ri = {3'd7, 3'd0, 3'd7};
    @(negedge clk);
    chk("p reset rd", 64'(p_rd), 64'd0);
    chk("p reset busy", 64'(p_busy), 64'd0);
    chk("p reset any", 64'(p_any), 64'd0);
    tick();
    p_we = 1'b1; p_wi = 3'd7; p_wd = 16'hBEEF; p_ri = '0;
    tick();
    p_we = 1'b0; p_ri = {3'd7, 3'd0, 3'd7};
    @(negedge clk);
    chk("p rd x7/x0/x7", 64'(p_rd), 64'h0000_BEEF_0000_BEEF);
    tick();
    p_set = 1'b1; p_si = 3'd2; p_ri = {3'd2, 3'd7, 3'd2};
    @(negedge clk);
    chk("p busy before set", 64'(p_busy), 64'd0);
    tick();
    p_set = 1'b0;
    @(negedge clk);
    chk("p busy pending", 64'(p_busy), 64'b101);
    chk("p any pending", 64'(p_any), 64'd1);
    chk("p rd pending", 64'(p_rd), {16'h0, 16'h0000, 16'hBEEF, 16'h0000});
    tick();
    p_clr = 1'b1; p_ci = 3'd2; p_we = 1'b1; p_wi = 3'd2; p_wd = 16'h1234;
    @(negedge clk);
    chk("p busy at clear", 64'(p_busy), 64'd0);
    chk("p rd at clear", 64'(p_rd), {16'h0, 16'h1234, 16'hBEEF, 16'h1234});
    tick();
    idle();
    p_ri = {3'd2, 3'd7, 3'd2};
    @(negedge clk);
    chk("p any after clear", 64'(p_any), 64'd0);
    tick();

    // Random phase on the default and no-bypass instances.
    for (int c = 0; c < 400; c++) begin
      nrst = ($urandom_range(0, 49) != 0);
      reg_write = 1'($urandom_range(0, 1));
      write_index = rnd_idx();
      write_data = $urandom;
      sb_set = ($urandom_range(0, 3) == 0);
      sb_set_index = rnd_idx();
      sb_clear = ($urandom_range(0, 2) == 0);
      sb_clear_index = rnd_idx();
      sb_flush = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 2))
          0: read_index[k*5 +: 5] = write_index;
          1: read_index[k*5 +: 5] = sb_clear_index;
          default: read_index[k*5 +: 5] = rnd_idx();
        endcase
      end
      @(negedge clk);
      model_check($sformatf("rand%0d", c));
      tick();
    end

    // Directed vectors: reset after random traffic, zero reg, bypass, scoreboard corners.
    tv.push_back(v(0,0, 0,0,0,            5,31, 0,0, 0,0, 0, 0,0,0,0, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            5,31, 0,0, 0,0, 0, 0,0,0,0, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 1,5,32'hDEADBEEF, 3,31, 0,0, 0,0, 0, 0,0,0,0, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            0,5,  0,0, 0,0, 0, 0,32'hDEADBEEF,0,32'hDEADBEEF, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 1,0,32'h12345678, 0,0,  1,0, 0,0, 0, 0,0,0,0, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            0,0,  0,0, 0,0, 0, 0,0,0,0, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 1,7,32'hA5A5A5A5, 7,7,  0,0, 0,0, 0, 32'hA5A5A5A5,32'hA5A5A5A5,0,0, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            7,7,  0,0, 0,0, 0, 32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            9,7,  1,9, 0,0, 0, 0,32'hA5A5A5A5,0,32'hA5A5A5A5, 2'b00,2'b00,0));
    for (int i = 0; i < 3; i++)
      tv.push_back(v(1,1, 0,0,0,          9,7,  0,0, 0,0, 0, 0,32'hA5A5A5A5,0,32'hA5A5A5A5, 2'b01,2'b01,1));
    tv.push_back(v(1,1, 1,9,32'h55,       9,7,  0,0, 1,9, 0, 32'h55,32'hA5A5A5A5,0,32'hA5A5A5A5, 2'b00,2'b01,1));
    tv.push_back(v(1,1, 0,0,0,            9,7,  0,0, 0,0, 0, 32'h55,32'hA5A5A5A5,32'h55,32'hA5A5A5A5, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            3,9,  1,3, 0,0, 0, 0,32'h55,0,32'h55, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            3,9,  1,3, 1,3, 0, 0,32'h55,0,32'h55, 2'b00,2'b01,1));
    tv.push_back(v(1,1, 0,0,0,            3,9,  0,0, 0,0, 0, 0,32'h55,0,32'h55, 2'b01,2'b01,1));
    tv.push_back(v(1,1, 1,4,32'h44,       3,4,  1,4, 0,0, 1, 0,32'h44,0,0, 2'b01,2'b01,1));
    tv.push_back(v(1,1, 0,0,0,            3,4,  0,0, 0,0, 0, 0,32'h44,0,32'h44, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            10,4, 0,0, 1,10,0, 0,32'h44,0,32'h44, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 1,12,32'h77,      12,4, 1,12,0,0, 0, 32'h77,32'h44,0,32'h44, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            12,4, 0,0, 0,0, 0, 32'h77,32'h44,32'h77,32'h44, 2'b01,2'b01,1));
    tv.push_back(v(0,0, 1,12,32'h99,      13,12,1,13,0,0, 0, 0,0,0,0, 2'b00,2'b00,0));
    tv.push_back(v(1,1, 0,0,0,            12,13,0,0, 0,0, 0, 0,0,0,0, 2'b00,2'b00,0));

    for (int i = 0; i < tv.size(); i++) begin
      idle();
      nrst = tv[i].rst_n; reg_write = tv[i].we; write_index = tv[i].wi;
      write_data = tv[i].wd; read_index = {tv[i].ri1, tv[i].ri0};
      sb_set = tv[i].set; sb_set_index = tv[i].si; sb_clear = tv[i].clr;
      sb_clear_index = tv[i].ci; sb_flush = tv[i].flush;
      @(negedge clk);
      if (tv[i].chk_en) begin
        chk($sformatf("vec%0d rd_byp", i), 64'(rd_a), {tv[i].e_rd1, tv[i].e_rd0});
        chk($sformatf("vec%0d rd_nobyp", i), 64'(rd_b), {tv[i].n_rd1, tv[i].n_rd0});
        chk($sformatf("vec%0d busy_byp", i), 64'(busy_a), 64'(tv[i].e_busy));
        chk($sformatf("vec%0d busy_nobyp", i), 64'(busy_b), 64'(tv[i].n_busy));
        chk($sformatf("vec%0d any", i), 64'(any_a), 64'(tv[i].e_any));
      end
      model_check($sformatf("vec%0d", i));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/t02_register_file_sb.md
Name: t02_register_file_sb

Overview:
- Parametrised successor to the core's integer register file.
- Adds configurable data width, register count and read-port count, plus optional same-cycle write-to-read bypass.
- Adds a pending-write scoreboard so the decode stage can detect RAW hazards against long-latency producers (loads, multi-cycle ALU ops).
- Sits between decode (read and scoreboard-issue side) and writeback (write and scoreboard-clear side).

Parameters:
- DATA_W, 32, width of each register.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of independent read ports, 1..4.
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never marked pending.
- BYPASS, 1, when 1, a write in the current cycle is forwarded to matching read ports in the same cycle.
- Localparam IDX_W = $clog2(NUM_REGS).

Ports:
- clk  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset.
- reg_write  input  1  write enable, writeback stage.
- write_index  input  IDX_W  destination register.
- write_data  input  DATA_W  data to write.
- read_index  input  NUM_RD*IDX_W  packed read indices; port k uses bits [k*IDX_W +: IDX_W].
- read_data  output  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
- read_busy  output  NUM_RD  port k is high when its register has a pending write that is not completing this cycle.
- sb_set  input  1  decode issued a long-latency producer.
- sb_set_index  input  IDX_W  destination of that producer.
- sb_clear  input  1  producer completed.
- sb_clear_index  input  IDX_W  completed destination; normally accompanies reg_write.
- sb_flush  input  1  pipeline flush; clears all pending bits.
- any_busy  output  1  OR of all pending bits, used for drain and fence.

Behaviour:
- Reset: synchronous, active low. At a rising clk edge with nRST=0, all registers are set to 0 and all pending bits to 0; all other inputs are ignored that cycle.
- Outputs after reset: read_data = 0 on every port, read_busy = 0, any_busy = 0.
- Reset asserted mid-operation discards any write, set or clear presented that cycle.
- Write: at a rising edge with nRST=1 and reg_write=1, register[write_index] takes write_data.
  - If ZERO_REG=1 and write_index=0, the write is dropped.
- Read: combinational, zero-cycle latency. read_data[k] = register[read_index[k]].
  - If ZERO_REG=1 and the index is 0, output is 0 regardless of storage.
  - If BYPASS=1, reg_write=1 and write_index equals the read index (and is not the zero register), output is write_data instead of the stored value.
  - Every read port bypasses independently. Several ports reading the same index all receive the same value.
- Scoreboard: one pending bit per register.
  - Next-state priority, highest first: sb_flush clears all bits; then sb_set sets bit[sb_set_index]; then sb_clear clears bit[sb_clear_index].
  - Set and clear on the same index in the same cycle: set wins, because a new producer replaces the completing one.
  - Set and clear on different indices apply independently.
  - sb_flush together with sb_set: flush wins and no bit is set. A write in that same cycle still lands.
  - With ZERO_REG=1, sb_set to index 0 is ignored.
  - sb_clear to a bit that is not pending has no effect and no error.
- read_busy[k] = pending[read_index[k]] AND NOT (BYPASS=1 AND sb_clear=1 AND sb_clear_index = read_index[k]).
  - This lets a consumer proceed in the cycle its producer writes back.
  - With BYPASS=0, read_busy is the raw pending bit.
- any_busy is the registered OR of the pending bits, with no bypass masking.
- With BYPASS=0, read-after-write has one-cycle latency: new data is visible on the cycle after the write edge.

Decomposition:
- Shared package t02_rf_pkg holds the default constants (DATA_W=32, NUM_REGS=32), the IDX_W derivation and typedefs reg_idx_t and reg_data_t.
- One natural sub-module, t02_rf_scoreboard: pending-bit array, set/clear/flush priority logic and any_busy.
- The top level holds the storage array, read muxes, bypass comparators and read_busy masking.

Test Plan:
- Reset: with nRST=0 for one edge after random writes, every port reads 0 and read_busy, any_busy are 0 → then write 0xDEADBEEF to x5 and read x5 on port 1 → 0xDEADBEEF on the next cycle.
- Zero register: write 0x12345678 to x0 with sb_set to x0 → x0 reads 0, read_busy is 0 and any_busy stays 0.
- Bypass: same cycle as reg_write of 0xA5A5A5A5 to x7, ports 0 and 1 both read x7 → both show 0xA5A5A5A5 combinationally. With BYPASS=0 they show the old value 0x0 until the next cycle.
- Scoreboard lifecycle: sb_set x9, then port 0 reads x9 → read_busy[0]=1 for 3 cycles. Then sb_clear x9 with reg_write 0x55 → read_busy[0]=0 and data 0x55 that cycle, and any_busy falls on the next cycle.
- Simultaneous events: pending x3, sb_clear x3 and sb_set x3 in the same cycle → x3 still pending afterwards. Then sb_flush with sb_set x4 → no bits pending and any_busy=0.
- Parameter sweep: DATA_W=16, NUM_REGS=8, NUM_RD=3. Write 0xBEEF to x7, then ports 0/1/2 read x7/x0/x7 → 0xBEEF/0x0000/0xBEEF.
